// File: rtl/uart_rx_controller_if.sv
// Handshake bundle between the UART receiver, uart_rx_controller and its downstream consumer.
// The slave modport is the controller's view; the master modport is the environment's view.
interface uart_rx_controller_if #(
  parameter int AW    = 3,
  parameter int CNT_W = 8
);
  logic [7:0]       rx_data;
  logic             rx_sent;
  logic [3:0]       rx_error;
  logic             rx_recieved;
  logic             flush;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [AW:0]      fifo_count;
  logic [CNT_W-1:0] err_cnt;
  logic [3:0]       last_error;
  logic [CNT_W-1:0] drop_cnt;

  modport slave (
    input  rx_data, rx_sent, rx_error, flush, out_ready,
    output rx_recieved, out_data, out_valid, fifo_count, err_cnt, last_error, drop_cnt
  );

  modport master (
    output rx_data, rx_sent, rx_error, flush, out_ready,
    input  rx_recieved, out_data, out_valid, fifo_count, err_cnt, last_error, drop_cnt
  );
endinterface

// File: rtl/uart_rx_controller.sv
// UART receive sequencer: acks receiver bytes, buffers them in a FIFO, tracks line errors.
// Define UART_RX_CTRL_DROP_EN to ack-and-discard bytes on a full FIFO instead of stalling.
module uart_rx_controller #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  uart_rx_controller_if.slave   bus
);

`ifdef UART_RX_CTRL_DROP_EN
  localparam bit DropEn = 1'b1;
`else
  localparam bit DropEn = 1'b0;
`endif

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {IDLE, ACK} state_e;

  state_e           state_q, state_d;
  logic             rx_recieved_q, rx_recieved_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [3:0]       last_error_q, last_error_d;
  logic [3:0]       err_q;
  logic [7:0]       mem [DEPTH];

  logic full, push, pop, err_event;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state_q;
    rx_recieved_d = rx_recieved_q;
    full          = (count_q == FullCount);
    push          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.rx_sent && (!full || DropEn)) begin
          push          = !full && !bus.flush;
          state_d       = ACK;
          rx_recieved_d = 1'b1;
        end
      end
      ACK: begin
        if (!bus.rx_sent) begin
          state_d       = IDLE;
          rx_recieved_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    pop       = (count_q != '0) && bus.out_ready && !bus.flush;
    err_event = (bus.rx_error != 4'd0) && (err_q == 4'd0);

    // Flush outranks both push and pop; the handshake itself keeps running.
    if (bus.flush) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      err_cnt_d    = '0;
      last_error_d = 4'd0;
    end else begin
      wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
      err_cnt_d    = (err_event && err_cnt_q != '1) ? err_cnt_q + 1'b1 : err_cnt_q;
      last_error_d = (bus.rx_error != 4'd0) ? bus.rx_error : last_error_q;
    end
  end

`ifdef UART_RX_CTRL_DROP_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic             drop;

  always_comb begin
    drop       = (state_q == IDLE) && bus.rx_sent && full;
    drop_cnt_d = drop_cnt_q;
    if (bus.flush)
      drop_cnt_d = '0;
    else if (drop && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt_q <= '0;
    else     drop_cnt_q <= drop_cnt_d;
  end

  assign bus.drop_cnt = drop_cnt_q;
`else
  assign bus.drop_cnt = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rx_recieved_q <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      err_cnt_q     <= '0;
      last_error_q  <= 4'd0;
      err_q         <= 4'd0;
    end else begin
      state_q       <= state_d;
      rx_recieved_q <= rx_recieved_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      err_cnt_q     <= err_cnt_d;
      last_error_q  <= last_error_d;
      err_q         <= bus.rx_error;
    end
  end

  // NOTE: the storage array is not reset; out_data is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.rx_data;
  end

  assign bus.rx_recieved = rx_recieved_q;
  assign bus.out_valid   = (count_q != '0);
  assign bus.out_data    = (count_q != '0) ? mem[rd_ptr_q] : 8'h00;
  assign bus.fifo_count  = count_q;
  assign bus.err_cnt     = err_cnt_q;
  assign bus.last_error  = last_error_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: a scoreboard queue holds accepted bytes and a
// monitor compares every delivered byte against its head.
module tb_uart_rx_controller;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] sb [$];

  uart_rx_controller_if #(.AW(AW), .CNT_W(CNT_W)) bus ();

  uart_rx_controller #(.DEPTH(DEPTH), .AW(AW), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Transfers happen at the next posedge whenever valid & ready hold here.
  always @(negedge clk) begin
    #1;
    if (!rst && !bus.flush && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_pop", {24'd0, bus.out_data}, 32'hFFFF_FFFF);
      end else begin
        check("pop_data", {24'd0, bus.out_data}, {24'd0, sb.pop_front()});
      end
    end
  end

  // Full receiver handshake: sent held one cycle past the ack, as the real receiver does.
  task automatic send_byte(input logic [7:0] d);
    bus.rx_data = d;
    bus.rx_sent = 1'b1;
    @(negedge clk);
    check("ack_rise", {31'd0, bus.rx_recieved}, 32'd1);
    sb.push_back(d);
    @(negedge clk);
    check("ack_hold", {31'd0, bus.rx_recieved}, 32'd1);
    bus.rx_sent = 1'b0;
    @(negedge clk);
    check("ack_fall", {31'd0, bus.rx_recieved}, 32'd0);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4 * DEPTH && bus.fifo_count != 0; i++) @(negedge clk);
    bus.out_ready = 1'b0;
    check("drain_count", {28'd0, bus.fifo_count}, 32'd0);
    check("drain_sb_empty", sb.size(), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rx_data   = 8'h00;
    bus.rx_sent   = 1'b0;
    bus.rx_error  = 4'd0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_ack",        {31'd0, bus.rx_recieved}, 32'd0);
    check("rst_valid",      {31'd0, bus.out_valid},   32'd0);
    check("rst_data",       {24'd0, bus.out_data},    32'd0);
    check("rst_count",      {28'd0, bus.fifo_count},  32'd0);
    check("rst_err_cnt",    {24'd0, bus.err_cnt},     32'd0);
    check("rst_last_error", {28'd0, bus.last_error},  32'd0);
    check("rst_drop_cnt",   {24'd0, bus.drop_cnt},    32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, no double capture while sent is held through ACK
    send_byte(8'h5A);
    check("t1_valid", {31'd0, bus.out_valid},  32'd1);
    check("t1_data",  {24'd0, bus.out_data},   32'h5A);
    check("t1_count", {28'd0, bus.fifo_count}, 32'd1);
    drain();

    // 2: fill, then ninth byte on a full FIFO
    for (int i = 1; i <= DEPTH; i++) send_byte(8'(i));
    check("t2_full_count", {28'd0, bus.fifo_count}, 32'd8);
    bus.rx_data = 8'h09;
    bus.rx_sent = 1'b1;
`ifdef UART_RX_CTRL_DROP_EN
    @(negedge clk);
    check("t2_drop_ack",   {31'd0, bus.rx_recieved}, 32'd1);
    check("t2_drop_cnt",   {24'd0, bus.drop_cnt},    32'd1);
    check("t2_drop_count", {28'd0, bus.fifo_count},  32'd8);
    @(negedge clk);
    bus.rx_sent = 1'b0;
    @(negedge clk);
`else
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_stall_ack",   {31'd0, bus.rx_recieved}, 32'd0);
      check("t2_stall_count", {28'd0, bus.fifo_count},  32'd8);
    end
    bus.rx_sent = 1'b0;
    @(negedge clk);
`endif
    drain();

    // 3: pointer wrap with the consumer always ready
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) send_byte(8'(8'h10 + i));
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t3_count",    {28'd0, bus.fifo_count}, 32'd0);
    check("t3_sb_empty", sb.size(), 32'd0);

    // 4: pop and request in the same cycle on a full FIFO
    for (int i = 0; i < DEPTH; i++) send_byte(8'(8'h30 + i));
    bus.rx_data   = 8'h38;
    bus.rx_sent   = 1'b1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("t4_pop_count", {28'd0, bus.fifo_count}, 32'd7);
`ifdef UART_RX_CTRL_DROP_EN
    check("t4_drop_ack", {31'd0, bus.rx_recieved}, 32'd1);
    check("t4_drop_cnt", {24'd0, bus.drop_cnt},    32'd2);
    @(negedge clk);
    bus.rx_sent = 1'b0;
    @(negedge clk);
`else
    check("t4_no_capture", {31'd0, bus.rx_recieved}, 32'd0);
    @(negedge clk);
    check("t4_capture_ack",   {31'd0, bus.rx_recieved}, 32'd1);
    check("t4_capture_count", {28'd0, bus.fifo_count},  32'd8);
    sb.push_back(8'h38);
    @(negedge clk);
    bus.rx_sent = 1'b0;
    @(negedge clk);
    check("t4_ack_fall", {31'd0, bus.rx_recieved}, 32'd0);
`endif
    drain();

    // 5: error edge detection, saturation, flush
    bus.rx_error = 4'd1; @(negedge clk);
    bus.rx_error = 4'd2; @(negedge clk);
    bus.rx_error = 4'd0; @(negedge clk);
    bus.rx_error = 4'd2; @(negedge clk);
    bus.rx_error = 4'd0; @(negedge clk);
    check("t5_err_cnt",    {24'd0, bus.err_cnt},    32'd2);
    check("t5_last_error", {28'd0, bus.last_error}, 32'd2);
    for (int i = 0; i < 300; i++) begin
      bus.rx_error = 4'd1; @(negedge clk);
      bus.rx_error = 4'd0; @(negedge clk);
    end
    check("t5_err_sat",      {24'd0, bus.err_cnt},    32'd255);
    check("t5_last_error_1", {28'd0, bus.last_error}, 32'd1);
    send_byte(8'h77);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    sb.delete();
    check("t5_flush_count",    {28'd0, bus.fifo_count}, 32'd0);
    check("t5_flush_valid",    {31'd0, bus.out_valid},  32'd0);
    check("t5_flush_err_cnt",  {24'd0, bus.err_cnt},    32'd0);
    check("t5_flush_last_err", {28'd0, bus.last_error}, 32'd0);
    check("t5_flush_drop_cnt", {24'd0, bus.drop_cnt},   32'd0);

    // 6: asynchronous reset in the middle of an ack
    bus.rx_data = 8'hC3;
    bus.rx_sent = 1'b1;
    @(negedge clk);
    check("t6_ack_before_rst", {31'd0, bus.rx_recieved}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_ack",   {31'd0, bus.rx_recieved}, 32'd0);
    check("t6_rst_count", {28'd0, bus.fifo_count},  32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_reack",       {31'd0, bus.rx_recieved}, 32'd1);
    check("t6_reack_count", {28'd0, bus.fifo_count},  32'd1);
    sb.push_back(8'hC3);
    @(negedge clk);
    bus.rx_sent = 1'b0;
    @(negedge clk);
    check("t6_ack_fall",  {31'd0, bus.rx_recieved}, 32'd0);
    check("t6_once",      {28'd0, bus.fifo_count},  32'd1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
